// File: rtl/demux1to4_stream.sv
// Registered 1-to-4 stream demux; each packet is locked to the channel its first beat selects.
// One-cycle latency; in_ready follows the routed channel's slot (empty or draining), independent of in_valid.
module demux1to4_stream #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [3:0]       out_last,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic             busy,
    output logic [1:0]       cur_sel
);

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    typedef struct packed {
        logic             last;
        logic [WIDTH-1:0] dat;
    } beat_t;

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    beat_t [3:0]      beat_q, beat_d;
    logic [3:0]       vld_q, vld_d;
    logic [1:0]       route;
    logic             accept;

    // Route is only taken from in_sel on a packet's first beat.
    always_comb begin
        route    = (state_q == IDLE) ? in_sel : sel_q;
        in_ready = ~vld_q[route] | out_ready[route];
        accept   = in_valid & in_ready;
        state_d  = state_q;
        sel_d    = sel_q;
        if (accept) begin
            if (state_q == IDLE) begin
                sel_d   = in_sel;
                state_d = in_last ? IDLE : PKT;
            end else if (in_last) begin
                state_d = IDLE;
            end
        end
    end

    // Load wins over drain so a full slot can turn over every cycle.
    always_comb begin
        beat_d = beat_q;
        vld_d  = vld_q;
        for (int i = 0; i < 4; i++) begin
            if (accept && (route == 2'(i))) begin
                beat_d[i] = '{last: in_last, dat: in_data};
                vld_d[i]  = 1'b1;
            end else if (out_ready[i]) begin
                vld_d[i]  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            beat_q  <= '0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            beat_q  <= beat_d;
            vld_q   <= vld_d;
        end
    end

    assign out_data0 = beat_q[0].dat;
    assign out_data1 = beat_q[1].dat;
    assign out_data2 = beat_q[2].dat;
    assign out_data3 = beat_q[3].dat;
    assign out_last  = {beat_q[3].last, beat_q[2].last, beat_q[1].last, beat_q[0].last};
    assign out_valid = vld_q;
    assign busy      = (state_q == PKT);
    assign cur_sel   = sel_q;

endmodule

// File: tb/tb_demux1to4_stream.sv
// Bench for demux1to4_stream: directed vector table, hand sequences, then random traffic vs a queue model.
module tb_demux1to4_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic [1:0] in_sel;
    logic       in_last;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data0, out_data1, out_data2, out_data3;
    logic [3:0] out_last;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic       busy;
    logic [1:0] cur_sel;
    logic [7:0] od [4];

    int n_cmp = 0;
    int n_err = 0;

    demux1to4_stream #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data0(out_data0), .out_data1(out_data1),
        .out_data2(out_data2), .out_data3(out_data3),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .cur_sel(cur_sel)
    );

    always #5 clk = ~clk;

    assign od[0] = out_data0;
    assign od[1] = out_data1;
    assign od[2] = out_data2;
    assign od[3] = out_data3;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d, input logic l);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        in_last  = l;
    endtask

    typedef struct {
        logic [1:0] sel;
        logic [7:0] data;
        logic       last;
        logic [3:0] exp_vld;
        logic [3:0] exp_last;
        logic [1:0] exp_ch;
        logic       exp_busy;
        logic [1:0] exp_cur;
    } vec_t;

    vec_t vt [8];

    // Behavioural model: one expected-beat queue per channel plus packet lock.
    logic [8:0] exp_q [4][$];
    logic       m_open;
    logic [1:0] m_sel;

    initial begin
        logic       pending;
        logic [1:0] rt;
        logic       exp_rdy;
        logic       acc;

        vt[0] = '{2'd0, 8'hA0, 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0, 2'd0};
        vt[1] = '{2'd1, 8'hA1, 1'b1, 4'b0010, 4'b0010, 2'd1, 1'b0, 2'd1};
        vt[2] = '{2'd2, 8'hA2, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0, 2'd2};
        vt[3] = '{2'd3, 8'hA3, 1'b1, 4'b1000, 4'b1000, 2'd3, 1'b0, 2'd3};
        vt[4] = '{2'd2, 8'hC0, 1'b0, 4'b0100, 4'b0000, 2'd2, 1'b1, 2'd2};
        vt[5] = '{2'd1, 8'hC1, 1'b0, 4'b0100, 4'b0000, 2'd2, 1'b1, 2'd2};
        vt[6] = '{2'd1, 8'hC2, 1'b0, 4'b0100, 4'b0000, 2'd2, 1'b1, 2'd2};
        vt[7] = '{2'd1, 8'hC3, 1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0, 2'd2};

        // Reset with in_valid high
        rst_n = 1'b0;
        out_ready = 4'b0000;
        drive(1'b1, 2'd3, 8'hFF, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 4'b0000);
        chk("rst_out_last", out_last, 4'b0000);
        chk("rst_busy", busy, 0);
        chk("rst_cur_sel", cur_sel, 0);
        chk("rst_data", {out_data3, out_data2, out_data1, out_data0}, 0);
        chk("rst_in_ready", in_ready, 1);

        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 2'd1, 8'h5A, 1'b1);
        #1 chk("first_in_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("first_valid", out_valid, 4'b0010);
        chk("first_data", out_data1, 8'h5A);
        chk("first_busy", busy, 0);
        @(negedge clk);
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        out_ready = 4'b1111;
        @(posedge clk);

        // Vector table: single-beat sweep, then packet lock to ch2
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drive(1'b1, vt[k].sel, vt[k].data, vt[k].last);
            #1 chk($sformatf("vec%0d_in_ready", k), in_ready, 1);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_valid", k), out_valid, vt[k].exp_vld);
            chk($sformatf("vec%0d_last", k), out_last & out_valid, vt[k].exp_last);
            chk($sformatf("vec%0d_data", k), od[vt[k].exp_ch], vt[k].data);
            chk($sformatf("vec%0d_busy", k), busy, vt[k].exp_busy);
            chk($sformatf("vec%0d_cur", k), cur_sel, vt[k].exp_cur);
        end
        @(negedge clk);
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        @(posedge clk); #1;
        chk("drain_all", out_valid, 4'b0000);

        // Backpressure on ch1
        @(negedge clk);
        out_ready = 4'b1101;
        drive(1'b1, 2'd1, 8'hB0, 1'b0);
        #1 chk("bp_rdy0", in_ready, 1);
        @(posedge clk); #1;
        chk("bp_d0", out_data1, 8'hB0);
        @(negedge clk);
        drive(1'b1, 2'd1, 8'hB1, 1'b0);
        #1 chk("bp_stall", in_ready, 0);
        @(posedge clk); #1;
        chk("bp_hold_data", out_data1, 8'hB0);
        chk("bp_hold_valid", out_valid, 4'b0010);
        chk("bp_busy", busy, 1);
        @(negedge clk);
        out_ready = 4'b1111;
        #1 chk("bp_release", in_ready, 1);
        @(posedge clk); #1;
        chk("bp_d1", out_data1, 8'hB1);
        @(negedge clk);
        drive(1'b1, 2'd3, 8'hB2, 1'b1);
        #1 chk("bp_rdy2", in_ready, 1);
        @(posedge clk); #1;
        chk("bp_d2", {out_last[1], out_data1}, {1'b1, 8'hB2});
        chk("bp_d2_valid", out_valid, 4'b0010);
        chk("bp_end_busy", busy, 0);
        @(negedge clk);
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        @(posedge clk); #1;
        chk("bp_drained", out_valid, 4'b0000);

        // Independent drain: ch0 held while ch3 streams
        @(negedge clk);
        out_ready = 4'b1110;
        drive(1'b1, 2'd0, 8'hD0, 1'b1);
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1'b1, 2'd3, 8'hE0 + 8'(k), k == 3);
            #1 chk($sformatf("ind_rdy%0d", k), in_ready, 1);
            @(posedge clk); #1;
            chk($sformatf("ind_d%0d", k), out_data3, 8'hE0 + 8'(k));
            chk($sformatf("ind_v%0d", k), out_valid, 4'b1001);
            chk($sformatf("ind_ch0_%0d", k), out_data0, 8'hD0);
        end
        @(negedge clk);
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        out_ready = 4'b1111;
        @(posedge clk); #1;
        chk("ind_release", out_valid, 4'b0000);

        // Reset mid-packet
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b1, 2'd1, 8'hF0 + 8'(k), 1'b0);
            @(posedge clk);
        end
        #1 chk("mid_busy_pre", busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        @(posedge clk); #1;
        chk("mid_busy", busy, 0);
        chk("mid_valid", out_valid, 4'b0000);
        chk("mid_cur", cur_sel, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 2'd0, 8'h77, 1'b1);
        @(posedge clk); #1;
        chk("mid_new_valid", out_valid, 4'b0001);
        chk("mid_new_data", out_data0, 8'h77);

        // Randomized traffic against the model, starting from a clean reset
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        @(posedge clk);
        m_open  = 1'b0;
        m_sel   = 2'd0;
        pending = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst_n     = 1'b1;
            out_ready = 4'($urandom);
            if (!pending) begin
                drive(($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom),
                      ($urandom_range(0, 2) == 0));
            end
            #1;
            rt      = m_open ? m_sel : in_sel;
            exp_rdy = (exp_q[rt].size() == 0) || out_ready[rt];
            chk("rnd_in_ready", in_ready, exp_rdy);
            chk("rnd_busy", busy, m_open);
            chk("rnd_cur", cur_sel, m_sel);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("rnd_valid%0d", i), out_valid[i], exp_q[i].size() != 0);
                if (exp_q[i].size() != 0) begin
                    chk($sformatf("rnd_beat%0d", i), {out_last[i], od[i]}, exp_q[i][0]);
                    if (out_ready[i]) void'(exp_q[i].pop_front());
                end
            end
            acc = in_valid && exp_rdy;
            if (acc) begin
                exp_q[rt].push_back({in_last, in_data});
                m_sel  = rt;
                m_open = !in_last;
            end
            pending = in_valid && !acc;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
